// File: rtl/mem_stack_sequencer_if.sv
// Op request / memory-control bundle between the pipeline front end and the stack sequencer.
// Latency: none; this file only groups wires.
// Backpressure: master holds op_valid/op_type until the slave raises ready.
interface mem_stack_sequencer_if;
    logic       op_valid;
    logic [2:0] op_type;
    logic       ready;
    logic       memory_read;
    logic       memory_write;
    logic       memory_push;
    logic       memory_pop;
    logic [1:0] memory_address_select;
    logic [1:0] memory_write_src_select;
    logic [1:0] ret_capture;
    logic       pc_load;
    logic       stack_fault;

    // Requester side: offers ops, observes the memory control beats.
    modport master (
        output op_valid, op_type,
        input  ready, memory_read, memory_write, memory_push, memory_pop,
        input  memory_address_select, memory_write_src_select, ret_capture,
        input  pc_load, stack_fault
    );

    // Sequencer side: accepts ops, drives one memory control beat per cycle.
    modport slave (
        input  op_valid, op_type,
        output ready, memory_read, memory_write, memory_push, memory_pop,
        output memory_address_select, memory_write_src_select, ret_capture,
        output pc_load, stack_fault
    );
endinterface

// File: rtl/mem_stack_sequencer.sv
// Sequences CALL/RET/INT/RTI stack beats; single-beat PUSH/POP/LDD/STD pass through. Optional bound check: MEM_SEQ_BOUND_CHECK_EN.
// Latency: 1 cycle from acceptance to beat 0; all memory controls are registered.
// Backpressure: ready low while a multi-beat op has beats left; new op accepted on the final beat (no bubble).
module mem_stack_sequencer #(
    parameter int STACK_DEPTH = 2048
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_stack_sequencer_if.slave bus
);

    localparam logic [2:0] OP_PUSH = 3'd0;
    localparam logic [2:0] OP_POP  = 3'd1;
    localparam logic [2:0] OP_CALL = 3'd2;
    localparam logic [2:0] OP_RET  = 3'd3;
    localparam logic [2:0] OP_INT  = 3'd4;
    localparam logic [2:0] OP_RTI  = 3'd5;
    localparam logic [2:0] OP_LDD  = 3'd6;
    localparam logic [2:0] OP_STD  = 3'd7;

    typedef enum logic {ST_IDLE, ST_BEAT} state_e;

    typedef struct packed {
        logic       rd;
        logic       wr;
        logic       push;
        logic       pop;
        logic [1:0] addr;
        logic [1:0] src;
        logic [1:0] cap;
        logic       pcl;
    } ctrl_t;

    // Control word for beat b of op.
    function automatic ctrl_t beat_ctrl(input logic [2:0] op, input logic [1:0] b);
        ctrl_t c;
        c = '0;
        case (op)
            OP_PUSH: begin c.wr = 1'b1; c.push = 1'b1; end
            OP_POP:  begin c.rd = 1'b1; c.pop = 1'b1; end
            OP_LDD:  begin c.rd = 1'b1; c.addr = 2'b01; end
            OP_STD:  begin c.wr = 1'b1; c.addr = 2'b01; end
            OP_CALL: begin
                c.wr   = 1'b1;
                c.push = 1'b1;
                c.src  = (b == 2'd0) ? 2'b10 : 2'b01;
            end
            OP_RET: begin
                c.rd  = 1'b1;
                c.pop = 1'b1;
                c.cap = (b == 2'd0) ? 2'b01 : 2'b10;
                c.pcl = (b == 2'd1);
            end
            OP_INT: begin
                if (b == 2'd3) begin
                    // Vector fetch: new PC low word comes from the vector slot.
                    c.rd   = 1'b1;
                    c.addr = 2'b10;
                    c.cap  = 2'b01;
                    c.pcl  = 1'b1;
                end else begin
                    c.wr   = 1'b1;
                    c.push = 1'b1;
                    case (b)
                        2'd0:    c.src = 2'b11;
                        2'd1:    c.src = 2'b10;
                        default: c.src = 2'b01;
                    endcase
                end
            end
            OP_RTI: begin
                c.rd  = 1'b1;
                c.pop = 1'b1;
                case (b)
                    2'd0:    c.cap = 2'b01;
                    2'd1:    c.cap = 2'b10;
                    default: c.cap = 2'b11;
                endcase
                c.pcl = (b == 2'd2);
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Index of the final beat for op.
    function automatic logic [1:0] last_beat(input logic [2:0] op);
        case (op)
            OP_CALL, OP_RET: return 2'd1;
            OP_RTI:          return 2'd2;
            OP_INT:          return 2'd3;
            default:         return 2'd0;
        endcase
    endfunction

    state_e     state;
    logic [1:0] b;
    logic [2:0] cur_op;
    ctrl_t      ctrl_q;
    ctrl_t      nxt_ctrl;
    logic       ready_w;
    logic       accept;
    logic       fault_op;

    assign ready_w = (state == ST_IDLE) || (b == last_beat(cur_op));
    assign accept  = bus.op_valid && ready_w;

`ifdef MEM_SEQ_BOUND_CHECK_EN
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic [DEPTH_W-1:0] depth;
    logic [31:0]        depth_ext;
    logic               fault_q;

    function automatic logic [31:0] push_words(input logic [2:0] op);
        case (op)
            OP_PUSH: return 32'd1;
            OP_CALL: return 32'd2;
            OP_INT:  return 32'd3;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] pop_words(input logic [2:0] op);
        case (op)
            OP_POP:  return 32'd1;
            OP_RET:  return 32'd2;
            OP_RTI:  return 32'd3;
            default: return 32'd0;
        endcase
    endfunction

    // Previous op's beats are all loaded by the time a new op can be accepted,
    // so depth already reflects everything ahead of the incoming op.
    assign depth_ext = 32'(depth);
    assign fault_op  = accept &&
                       (((depth_ext + push_words(bus.op_type)) > 32'(STACK_DEPTH)) ||
                        (pop_words(bus.op_type) > depth_ext));

    // Depth follows each push/pop beat as it is loaded; fault is a one-cycle pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            depth   <= '0;
            fault_q <= 1'b0;
        end else begin
            depth   <= depth + DEPTH_W'(nxt_ctrl.push) - DEPTH_W'(nxt_ctrl.pop);
            fault_q <= fault_op;
        end
    end

    assign bus.stack_fault = fault_q;
`else
    assign fault_op        = 1'b0;
    assign bus.stack_fault = 1'b0;
`endif

    // Select the control word to present next cycle: new op beat 0, next beat, or idle.
    always_comb begin
        nxt_ctrl = '0;
        if (accept) begin
            if (!fault_op) begin
                nxt_ctrl = beat_ctrl(bus.op_type, 2'd0);
            end
        end else if (state == ST_BEAT && b != last_beat(cur_op)) begin
            nxt_ctrl = beat_ctrl(cur_op, b + 2'd1);
        end
    end

    // Sequencer FSM: captures the op on acceptance and walks its beats.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            b      <= 2'd0;
            cur_op <= OP_PUSH;
            ctrl_q <= '0;
        end else begin
            ctrl_q <= nxt_ctrl;
            if (accept && !fault_op) begin
                state  <= ST_BEAT;
                b      <= 2'd0;
                cur_op <= bus.op_type;
            end else if (!accept && state == ST_BEAT && b != last_beat(cur_op)) begin
                b <= b + 2'd1;
            end else begin
                state <= ST_IDLE;
                b     <= 2'd0;
            end
        end
    end

    assign bus.ready                   = ready_w;
    assign bus.memory_read             = ctrl_q.rd;
    assign bus.memory_write            = ctrl_q.wr;
    assign bus.memory_push             = ctrl_q.push;
    assign bus.memory_pop              = ctrl_q.pop;
    assign bus.memory_address_select   = ctrl_q.addr;
    assign bus.memory_write_src_select = ctrl_q.src;
    assign bus.ret_capture             = ctrl_q.cap;
    assign bus.pc_load                 = ctrl_q.pcl;

endmodule
